// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
package adder_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int BLK_DEF   = 4;

  function automatic int nblk(input int w, input int b);
    return w / b;
  endfunction

  function automatic bit width_ok(input int w, input int b);
    return (b > 0) && (w > 0) && ((w % b) == 0);
  endfunction

  localparam bit DEF_OK = width_ok(WIDTH_DEF, BLK_DEF);

endpackage

// File: rtl/carry_select_adder_pipe_block_candidate_adder.sv
// BLK-bit dual adder: sums for both carry-in candidates of one block.
module block_candidate_adder #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  output logic [BLK-1:0] s0,
  output logic           c0,
  output logic [BLK-1:0] s1,
  output logic           c1
);

  logic [BLK:0] ext_a;
  logic [BLK:0] ext_b;

  assign ext_a = {1'b0, a};
  assign ext_b = {1'b0, b};

  assign {c0, s0} = ext_a + ext_b;
  assign {c1, s1} = ext_a + ext_b + (BLK+1)'(1);

endmodule

// File: rtl/carry_select_adder_pipe.sv
// Two-stage carry-select adder: stage 1 candidates, stage 2 select.
module carry_select_adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BLK   = BLK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NBLK = nblk(WIDTH, BLK);

  if (!width_ok(WIDTH, BLK)) begin : g_bad_width
    $error("WIDTH must be a multiple of BLK");
  end

  logic [NBLK-1:0][BLK-1:0] g_s0;
  logic [NBLK-1:0][BLK-1:0] g_s1;
  logic [NBLK-1:0]          g_c0;
  logic [NBLK-1:0]          g_c1;

  logic [NBLK-1:0][BLK-1:0] s0_q;
  logic [NBLK-1:0][BLK-1:0] s1_q;
  logic [NBLK-1:0]          c0_q;
  logic [NBLK-1:0]          c1_q;
  logic                     cin_q;
  logic                     s1_valid;

  logic [WIDTH-1:0] sel_sum;
  logic             sel_cout;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             s2_valid;

  logic adv1;
  logic adv2;
  logic accept;

  for (genvar i = 0; i < NBLK; i++) begin : g_cand
    block_candidate_adder #(
      .BLK(BLK)
    ) u_cand (
      .a (a[i*BLK +: BLK]),
      .b (b[i*BLK +: BLK]),
      .s0(g_s0[i]),
      .c0(g_c0[i]),
      .s1(g_s1[i]),
      .c1(g_c1[i])
    );
  end

  assign adv2     = ~s2_valid | out_ready;
  assign adv1     = s1_valid & adv2;
  assign in_ready = ~s1_valid | adv2;
  assign accept   = in_valid & in_ready;

  // Block carry ripples through the registered candidates.
  always_comb begin : sel_p
    logic k;
    k       = cin_q;
    sel_sum = '0;
    for (int i = 0; i < NBLK; i++) begin
      sel_sum[i*BLK +: BLK] = k ? s1_q[i] : s0_q[i];
      k = k ? c1_q[i] : c0_q[i];
    end
    sel_cout = k;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s0_q     <= '0;
      s1_q     <= '0;
      c0_q     <= '0;
      c1_q     <= '0;
      cin_q    <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s0_q     <= g_s0;
        s1_q     <= g_s1;
        c0_q     <= g_c0;
        c1_q     <= g_c1;
        cin_q    <= cin;
      end else if (adv1) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      if (adv1) begin
        s2_valid <= 1'b1;
        sum_q    <= sel_sum;
        cout_q   <= sel_cout;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_carry_select_adder_pipe.sv
// Directed and random stream checks for carry_select_adder_pipe.
module tb_carry_select_adder_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;

  int n_cmp = 0;
  int n_bad = 0;

  carry_select_adder_pipe #(
    .WIDTH(16),
    .BLK  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] va,
                       input logic [15:0] vb,
                       input logic vc);
    in_valid = 1'b1;
    a = va;
    b = vb;
    cin = vc;
  endtask

  // One beat through an idle pipe with out_ready held high.
  task automatic one(input string tag,
                     input logic [15:0] va,
                     input logic [15:0] vb,
                     input logic vc,
                     input logic [16:0] exp);
    out_ready = 1'b1;
    drive(va, vb, vc);
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'({cout, sum}), 32'(exp));
    tick();
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  logic [16:0] q[$];
  logic [16:0] ref_v;
  int sent;
  int cyc;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 16'h0001;
    b = 16'h0001;
    cin = 1'b0;
    out_ready = 1'b1;

    // Reset with in_valid asserted
    tick();
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'h0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    one("cross", 16'h00FF, 16'h0001, 1'b0, 17'h00100);
    one("full", 16'hFFFF, 16'h0000, 1'b1, 17'h10000);

    // Back-to-back beats
    out_ready = 1'b1;
    drive(16'h1234, 16'h4321, 1'b0);
    tick();
    drive(16'h8000, 16'h8000, 1'b0);
    tick();
    chk("b2b0_v", 32'(out_valid), 32'd1);
    chk("b2b0", 32'({cout, sum}), 32'h05555);
    drive(16'h7FFF, 16'h0001, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("b2b1_v", 32'(out_valid), 32'd1);
    chk("b2b1", 32'({cout, sum}), 32'h10000);
    tick();
    chk("b2b2_v", 32'(out_valid), 32'd1);
    chk("b2b2", 32'({cout, sum}), 32'h08001);
    tick();
    chk("b2b_end", 32'(out_valid), 32'd0);

    // Stall with four beats offered
    out_ready = 1'b0;
    drive(16'h0001, 16'h0002, 1'b0);
    tick();
    chk("st_rdy0", 32'(in_ready), 32'd1);
    drive(16'h1111, 16'h1111, 1'b0);
    tick();
    chk("st_rdy1", 32'(in_ready), 32'd0);
    drive(16'hF000, 16'h1000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("st_hold_v", 32'(out_valid), 32'd1);
      chk("st_hold", 32'({cout, sum}), 32'h00003);
      chk("st_rdy", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("st_rdy_go", 32'(in_ready), 32'd1);
    tick();
    chk("st_o1", 32'({cout, sum}), 32'h02222);
    drive(16'hABCD, 16'h1234, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("st_o2", 32'({cout, sum}), 32'h10000);
    tick();
    chk("st_o3_v", 32'(out_valid), 32'd1);
    chk("st_o3", 32'({cout, sum}), 32'h0BE02);
    tick();
    chk("st_end", 32'(out_valid), 32'd0);

    // Asynchronous reset with two beats in flight
    out_ready = 1'b0;
    drive(16'h0101, 16'h0202, 1'b0);
    tick();
    drive(16'h0303, 16'h0404, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("mid_v_pre", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_v", 32'(out_valid), 32'd0);
    chk("mid_sum", 32'(sum), 32'h0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("mid_stale", 32'(out_valid), 32'd0);
    one("mid_new", 16'h2468, 16'h1357, 1'b1, 17'h037C0);

    // Random stream with random stalls against a+b+cin
    sent = 0;
    cyc = 0;
    in_valid = 1'b0;
    while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
      in_valid = (sent < 10000) && ($urandom_range(3) != 0);
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_extra", 32'(out_valid), 32'd0);
        end else begin
          ref_v = q.pop_front();
          chk("rnd", 32'({cout, sum}), 32'(ref_v));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(17'(a) + 17'(b) + 17'(cin));
        sent++;
      end
      tick();
      cyc++;
    end
    chk("rnd_left", 32'(q.size()), 32'd0);
    chk("rnd_sent", 32'(sent), 32'd10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
